dmem_portb_arbiter: RTL and testbench
=====================================

# dmem_portb_arbiter

Arbiter for DMEM port B, which is shared between the accelerator (256-bit row reads of the input activations) and the CCD capture path (256-bit row writes). It replaces the fixed priority address mux in the top-level wrapper with a per-cycle req/gnt arbiter that bounds bursts and routes read data back to the accelerator. It sits between `Accelerator`/CCD and the `ram` port B pins. Port A (CPU) is unaffected.

## Interface
- `ADDR_W`, default 7: port-B row address width.
- `DATA_W`, default 256: port-B data width (16 × 16-bit).
- `RD_LAT`, default 1, legal range 1..3: cycles from `ram_rden_b` to valid `ram_q_b`.
- `BURST_MAX`, default 4, legal range ≥1: maximum consecutive grants to one requester while the other is requesting.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `acc_req` in 1: accelerator read request.
- `acc_addr` in ADDR_W: accelerator read row.
- `acc_gnt` out 1: read accepted this cycle.
- `acc_rvalid` out 1: `acc_rdata` valid.
- `acc_rdata` out DATA_W: read data.
- `ccd_req` in 1: CCD write request.
- `ccd_addr` in ADDR_W: CCD write row.
- `ccd_data` in DATA_W: CCD write data.
- `ccd_gnt` out 1: write performed this cycle.
- `ram_addr_b` out ADDR_W: port B address.
- `ram_data_b` out DATA_W: port B write data.
- `ram_rden_b` out 1: port B read enable.
- `ram_wren_b` out 1: port B write enable.
- `ram_q_b` in DATA_W: port B read data.

## Operation
- **Transfer rule.** A transfer occurs when `req` and `gnt` are high in the same cycle. The requester holds `addr` and `data` stable while `req` is high and `gnt` is low. `gnt` is combinational from `req` and registered arbiter state.
- **Grant exclusivity.** At most one grant per cycle. `ram_*` strobes equal the granted requester's strobe. With no grant, the address and data outputs are 0 and the strobes are 0.
- **Registered state.**
  - `owner` (NONE/ACC/CCD): grant holder last cycle.
  - `last`: most recent owner; resets to CCD so ACC wins the first tie.
  - `run_cnt` (clog2(BURST_MAX+1) bits): consecutive grants to `owner`.
- **Decision, per cycle:**
  - Only one requester requesting: it is granted.
  - Both requesting and `owner`∈{ACC,CCD} with `run_cnt` < BURST_MAX: `owner` is granted.
  - Both requesting and `run_cnt` == BURST_MAX: the other requester is granted.
  - Both requesting and `owner`==NONE: the requester ≠ `last` is granted.
  - Neither requesting: `owner`←NONE and `run_cnt`←0.
- **Counter update.**
  - Grant to the same requester as `owner`: `run_cnt` increments, saturating at BURST_MAX.
  - Grant to a different requester: `run_cnt`←1 and `owner` and `last` are updated.
- **Read return.**
  - A `rden` shift register RD_LAT deep drives `acc_rvalid` = stage[RD_LAT-1].
  - `acc_rdata` = `ram_q_b` when `acc_rvalid` is high, 0 otherwise.
  - Reads are returned in order. Back-to-back reads give one `rvalid` per cycle.
- **Same-row ordering.** A CCD write granted in cycle N followed by an ACC read of the same row granted in cycle N+1 returns the new data. There is no forwarding inside the block. A same-cycle conflict is impossible by exclusivity.

## Timing
- **Reset values.** All outputs are 0. `owner`=NONE, `last`=CCD, `run_cnt`=0, read pipe cleared.
- **Reset mid-operation.** Grants drop in the reset cycle. In-flight reads never produce `acc_rvalid`.
- **Latency.** Zero-cycle grant. Read data arrives RD_LAT cycles after `acc_gnt` (RD_LAT=1: cycle N+1). Writes complete in the grant cycle.
- **Throughput.** One transfer per cycle.
- **Starvation bound.** Worst-case wait for a continuously requesting port is BURST_MAX cycles.
- **Request withdrawal.** Dropping `req` without a grant is legal. No state is kept for it.

## Structure
- Package `dmem_arb_pkg`: `owner_e` enum {OWN_NONE, OWN_ACC, OWN_CCD}, default `ADDR_W` and `DATA_W` constants.
- Sub-module `rd_valid_pipe`: a parameterised RD_LAT-deep valid shift register with synchronous clear.
- Everything else is a single always_ff plus a combinational grant block.

## Test plan
- **Reset defaults:** hold `rst`=1 with both `req`=1 → all outputs 0. Release `rst` with both requesting → `acc_gnt`=1 in the first cycle.
- **Single ACC read:** `acc_req` with `acc_addr`=7'h05 and `ram_q_b` returning a row pattern → `ram_rden_b`=1 with address 5 in cycle N. In cycle N+1, `acc_rvalid`=1 and `acc_rdata` equals the pattern.
- **Burst fairness:** BURST_MAX=4, both requesting continuously → grant sequence ACC×4, CCD×4, ACC×4, with no idle cycles.
- **Write then read:** CCD writes 256'hA5…A5 to row 9, then ACC reads row 9 → `acc_rdata`=256'hA5…A5.
- **Reset mid-read:** assert `rst` in the cycle after an `acc_gnt` → `acc_rvalid` stays 0 and `owner` returns to NONE.
- **RD_LAT=3 back-to-back reads:** 5 back-to-back reads → 5 consecutive `acc_rvalid` pulses starting 3 cycles after the first grant.

Source files
------------

// File: rtl/dmem_portb_arbiter_pkg.sv
// Shared types and default widths for the DMEM port-B arbiter slice.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_ACC  = 2'd1,
      OWN_CCD  = 2'd2
   } owner_e;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 256;

endpackage

// File: rtl/dmem_portb_arbiter_if.sv
// Bundle of accelerator, CCD and RAM port-B signals around the arbiter.
interface dmem_portb_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              acc_req;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_gnt;
   logic              acc_rvalid;
   logic [DATA_W-1:0] acc_rdata;
   logic              ccd_req;
   logic [ADDR_W-1:0] ccd_addr;
   logic [DATA_W-1:0] ccd_data;
   logic              ccd_gnt;
   logic [ADDR_W-1:0] ram_addr_b;
   logic [DATA_W-1:0] ram_data_b;
   logic              ram_rden_b;
   logic              ram_wren_b;
   logic [DATA_W-1:0] ram_q_b;

   // Requesters and the RAM model sit on the master side.
   modport master (
      output acc_req, acc_addr, ccd_req, ccd_addr, ccd_data, ram_q_b,
      input  acc_gnt, acc_rvalid, acc_rdata, ccd_gnt,
      input  ram_addr_b, ram_data_b, ram_rden_b, ram_wren_b
   );

   modport slave (
      input  acc_req, acc_addr, ccd_req, ccd_addr, ccd_data, ram_q_b,
      output acc_gnt, acc_rvalid, acc_rdata, ccd_gnt,
      output ram_addr_b, ram_data_b, ram_rden_b, ram_wren_b
   );

endinterface

// File: rtl/dmem_portb_arbiter_rd_valid_pipe.sv
// Read-valid delay line matching the port-B read latency, cleared by reset.
module rd_valid_pipe
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clk) begin
      if (clr) begin
         stage <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Per-cycle req/gnt arbiter for DMEM port B: accelerator reads vs CCD writes,
// with bounded bursts under contention and in-order read-data return.
module dmem_portb_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 4
) (
   input logic             clk,
   input logic             rst,
   dmem_portb_arbiter_if.slave bus
);

   localparam int              CNT_W   = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(BURST_MAX);

   owner_e            owner;
   owner_e            last;
   owner_e            grant;
   logic [CNT_W-1:0]  run_cnt;
   logic              gnt_acc;
   logic              gnt_ccd;
   logic              rd_valid;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] data_mux;

   // Under contention the holder keeps the port until its run saturates;
   // from idle the side that did not win most recently goes first.
   always_comb begin
      grant = OWN_NONE;
      if (rst) begin
         grant = OWN_NONE;
      end else if (bus.acc_req && !bus.ccd_req) begin
         grant = OWN_ACC;
      end else if (!bus.acc_req && bus.ccd_req) begin
         grant = OWN_CCD;
      end else if (bus.acc_req && bus.ccd_req) begin
         if (owner == OWN_NONE) begin
            grant = (last == OWN_ACC) ? OWN_CCD : OWN_ACC;
         end else if (run_cnt < RUN_MAX) begin
            grant = owner;
         end else begin
            grant = (owner == OWN_ACC) ? OWN_CCD : OWN_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= OWN_NONE;
         last    <= OWN_CCD;
         run_cnt <= '0;
      end else if (grant == OWN_NONE) begin
         owner   <= OWN_NONE;
         run_cnt <= '0;
      end else if (grant == owner) begin
         if (run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + 1'b1;
         end
      end else begin
         owner   <= grant;
         last    <= grant;
         run_cnt <= CNT_W'(1);
      end
   end

   assign gnt_acc  = (grant == OWN_ACC);
   assign gnt_ccd  = (grant == OWN_CCD);
   assign addr_mux = gnt_acc ? bus.acc_addr : (gnt_ccd ? bus.ccd_addr : '0);
   assign data_mux = gnt_ccd ? bus.ccd_data : '0;

   assign bus.acc_gnt    = gnt_acc;
   assign bus.ccd_gnt    = gnt_ccd;
   assign bus.ram_addr_b = addr_mux;
   assign bus.ram_data_b = data_mux;
   assign bus.ram_rden_b = gnt_acc;
   assign bus.ram_wren_b = gnt_ccd;

   rd_valid_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_valid_pipe (
      .clk  (clk),
      .clr  (rst),
      .din  (gnt_acc),
      .dout (rd_valid)
   );

   // Masking with rst keeps a read that was in flight across reset silent.
   assign bus.acc_rvalid = rd_valid & ~rst;
   assign bus.acc_rdata  = bus.acc_rvalid ? bus.ram_q_b : '0;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus,
// each with a RAM model, checked every cycle against a fairness/return model.
module tb_dmem_portb_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 7;
   localparam int DW = 256;
   localparam int BM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          acc_req = 1'b0;
   logic          ccd_req = 1'b0;
   logic [AW-1:0] acc_addr = '0;
   logic [AW-1:0] ccd_addr = '0;
   logic [DW-1:0] ccd_data = '0;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   always #5 clk = ~clk;

   dmem_portb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   dmem_portb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   assign bus1.acc_req  = acc_req;
   assign bus1.acc_addr = acc_addr;
   assign bus1.ccd_req  = ccd_req;
   assign bus1.ccd_addr = ccd_addr;
   assign bus1.ccd_data = ccd_data;
   assign bus3.acc_req  = acc_req;
   assign bus3.acc_addr = acc_addr;
   assign bus3.ccd_req  = ccd_req;
   assign bus3.ccd_addr = ccd_addr;
   assign bus3.ccd_data = ccd_data;

   dmem_portb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .BURST_MAX(BM)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   dmem_portb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .BURST_MAX(BM)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   // RAM models for port B at latency 1 and 3.
   logic [DW-1:0] mem1 [0:127];
   logic [DW-1:0] mem3 [0:127];
   logic [DW-1:0] mem_m [0:127];
   logic [DW-1:0] q1;
   logic [DW-1:0] q3 [0:2];

   assign bus1.ram_q_b = q1;
   assign bus3.ram_q_b = q3[2];

   function automatic logic [DW-1:0] row_pat(int r);
      logic [7:0] b;
      b = 8'(r);
      return {16{b, 8'hC3}};
   endfunction

   initial begin
      for (int r = 0; r < 128; r++) begin
         mem1[r]  <= row_pat(r);
         mem3[r]  <= row_pat(r);
         mem_m[r]  = row_pat(r);
      end
      q1    <= '0;
      q3[0] <= '0;
      q3[1] <= '0;
      q3[2] <= '0;
   end

   always @(posedge clk) begin
      if (bus1.ram_wren_b) mem1[bus1.ram_addr_b] <= bus1.ram_data_b;
      if (bus1.ram_rden_b) q1 <= mem1[bus1.ram_addr_b];
      if (bus3.ram_wren_b) mem3[bus3.ram_addr_b] <= bus3.ram_data_b;
      if (bus3.ram_rden_b) q3[0] <= mem3[bus3.ram_addr_b];
      q3[1] <= q3[0];
      q3[2] <= q3[1];
   end

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Model: who won each cycle, whether reset hit, and what row data was due.
   int            holder   = 0;
   int            streak   = 0;
   int            prev_win = 2;
   int            m_win;
   logic [AW-1:0] m_addr;
   logic          hist_g   [0:4095];
   logic          hist_rst [0:4095];
   logic [DW-1:0] hist_d   [0:4095];

   function automatic logic exp_valid(int lat, int c);
      if (c < lat) return 1'b0;
      if (!hist_g[c-lat]) return 1'b0;
      for (int k = c - lat + 1; k <= c; k++) begin
         if (hist_rst[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] exp_rdata(int lat, int c);
      return exp_valid(lat, c) ? hist_d[c-lat] : '0;
   endfunction

   always @(negedge clk) begin
      m_win = 0;
      if (!rst) begin
         if (acc_req && !ccd_req)      m_win = 1;
         else if (ccd_req && !acc_req) m_win = 2;
         else if (acc_req && ccd_req) begin
            if (holder == 0)          m_win = 3 - prev_win;
            else if (streak < BM)     m_win = holder;
            else                      m_win = 3 - holder;
         end
      end
      hist_rst[cyc] = rst;
      hist_g[cyc]   = (m_win == 1);
      hist_d[cyc]   = mem_m[acc_addr];
      m_addr = (m_win == 1) ? acc_addr : ((m_win == 2) ? ccd_addr : '0);

      check_output("acc_gnt",     DW'(bus1.acc_gnt),    DW'(m_win == 1));
      check_output("ccd_gnt",     DW'(bus1.ccd_gnt),    DW'(m_win == 2));
      check_output("ram_rden_b",  DW'(bus1.ram_rden_b), DW'(m_win == 1));
      check_output("ram_wren_b",  DW'(bus1.ram_wren_b), DW'(m_win == 2));
      check_output("ram_addr_b",  DW'(bus1.ram_addr_b), DW'(m_addr));
      check_output("ram_data_b",  bus1.ram_data_b,      (m_win == 2) ? ccd_data : '0);
      check_output("acc_rvalid",  DW'(bus1.acc_rvalid), DW'(exp_valid(1, cyc)));
      check_output("acc_rdata",   bus1.acc_rdata,       exp_rdata(1, cyc));
      check_output("acc_gnt_l3",  DW'(bus3.acc_gnt),    DW'(m_win == 1));
      check_output("ccd_gnt_l3",  DW'(bus3.ccd_gnt),    DW'(m_win == 2));
      check_output("ram_addr_l3", DW'(bus3.ram_addr_b), DW'(m_addr));
      check_output("rvalid_l3",   DW'(bus3.acc_rvalid), DW'(exp_valid(3, cyc)));
      check_output("rdata_l3",    bus3.acc_rdata,       exp_rdata(3, cyc));

      if (rst) begin
         holder = 0; streak = 0; prev_win = 2;
      end else if (m_win == 0) begin
         holder = 0; streak = 0;
      end else if (m_win == holder) begin
         streak = (streak < BM) ? streak + 1 : BM;
      end else begin
         holder = m_win; prev_win = m_win; streak = 1;
      end
      if (m_win == 2) mem_m[ccd_addr] = ccd_data;
      cyc++;
   end

   // Drive one cycle of inputs just after the edge, then park mid-cycle.
   task automatic apply_stimulus(input logic r, input logic ar, input logic [AW-1:0] aa,
                                 input logic cr, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      @(posedge clk);
      #1;
      rst = r; acc_req = ar; acc_addr = aa; ccd_req = cr; ccd_addr = ca; ccd_data = cd;
      @(negedge clk);
      #1;
   endtask

   logic [11:0] seq_acc;
   logic [11:0] seq_ccd;
   logic [8:0]  vpat;

   initial begin
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b1, 7'd2, 1'b1, 7'd3, {32{8'h77}});
         check_output("rst_strobes", DW'({bus1.acc_gnt, bus1.ccd_gnt, bus1.ram_rden_b,
                                          bus1.ram_wren_b, bus1.acc_rvalid}), DW'(0));
         check_output("rst_addr", DW'(bus1.ram_addr_b), DW'(0));
         check_output("rst_data", bus1.ram_data_b, DW'(0));
      end

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(1'b0, 1'b1, 7'd1, 1'b1, 7'd20, {32{8'h11}});
         if (i == 0) check_output("first_gnt_acc", DW'(bus1.acc_gnt), DW'(1));
         seq_acc[11-i] = bus1.acc_gnt;
         seq_ccd[11-i] = bus1.ccd_gnt;
      end
      check_output("burst_seq_acc", DW'(seq_acc), DW'(12'b1111_0000_1111));
      check_output("burst_seq_ccd", DW'(seq_ccd), DW'(12'b0000_1111_0000));
      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);

      apply_stimulus(1'b0, 1'b1, 7'h05, 1'b0, 7'd0, '0);
      check_output("read_rden", DW'(bus1.ram_rden_b), DW'(1));
      check_output("read_addr", DW'(bus1.ram_addr_b), DW'(5));
      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);
      check_output("read_rvalid", DW'(bus1.acc_rvalid), DW'(1));
      check_output("read_rdata", bus1.acc_rdata, {16{16'h05C3}});

      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'd9, {32{8'hA5}});
      check_output("wr_data", bus1.ram_data_b, {32{8'hA5}});
      apply_stimulus(1'b0, 1'b1, 7'd9, 1'b0, 7'd0, '0);
      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);
      check_output("wr_rd_data", bus1.acc_rdata, {32{8'hA5}});
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);

      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'd30, {32{8'h5A}});
      apply_stimulus(1'b0, 1'b1, 7'd3, 1'b0, 7'd0, '0);
      apply_stimulus(1'b1, 1'b1, 7'd3, 1'b0, 7'd0, '0);
      check_output("midrst_gnt", DW'(bus1.acc_gnt), DW'(0));
      check_output("midrst_rvalid", DW'(bus1.acc_rvalid), DW'(0));
      apply_stimulus(1'b0, 1'b1, 7'd4, 1'b1, 7'd31, {32{8'h3C}});
      check_output("postrst_acc_wins", DW'(bus1.acc_gnt), DW'(1));
      check_output("postrst_rvalid", DW'(bus1.acc_rvalid), DW'(0));
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);

      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 7'(i), 1'b0, 7'd0, '0);
      apply_stimulus(1'b0, 1'b1, 7'd6, 1'b1, 7'd40, {32{8'hE1}});
      check_output("sat_switch_ccd", DW'(bus1.ccd_gnt), DW'(1));
      apply_stimulus(1'b0, 1'b1, 7'd6, 1'b1, 7'd41, {32{8'hE2}});
      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'd42, {32{8'hE3}});
      apply_stimulus(1'b0, 1'b1, 7'd40, 1'b0, 7'd0, '0);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);

      for (int i = 0; i < 9; i++) begin
         if (i < 5) apply_stimulus(1'b0, 1'b1, 7'(10 + i), 1'b0, 7'd0, '0);
         else       apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);
         vpat[8-i] = bus3.acc_rvalid;
      end
      check_output("lat3_rvalid_pattern", DW'(vpat), DW'(9'b000111110));
      apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
